// File: rtl/adc_acq_sequencer.sv
// adc_acq_sequencer
// Drives a dual-channel serial ADC controller through its reset/enable/ready
// handshake. Each start request runs 2^n conversions, optionally paced by a
// minimum TRIG-to-TRIG interval, and presents the truncated average of each
// channel.
module adc_acq_sequencer #(
  parameter int SAMPLE_BITS  = 14,
  parameter int MAX_LOG2_AVG = 4,
  parameter int TIMEOUT      = 1023,
  parameter int RESET_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic [2:0]             log2_avg,
  input  logic [15:0]            interval,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [SAMPLE_BITS-1:0] avg_a,
  output logic [SAMPLE_BITS-1:0] avg_b,
  output logic                   adc_enable,
  output logic                   adc_reset,
  input  logic                   adc_ready,
  input  logic [SAMPLE_BITS-1:0] adc_out_a,
  input  logic [SAMPLE_BITS-1:0] adc_out_b
);

  localparam int ACC_W = SAMPLE_BITS + MAX_LOG2_AVG;
  localparam int CNT_W = MAX_LOG2_AVG + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RC_W  = $clog2(RESET_CYCLES + 1);
  localparam logic [2:0] MAX_N = 3'(MAX_LOG2_AVG);

  typedef enum logic [3:0] {
    S_RST_ADC,
    S_INIT_WAIT,
    S_IDLE,
    S_TRIG,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_GAP,
    S_FINISH,
    S_ERR
  } state_t;

  // Truncating divide by 2^sh; the sum of 2^sh samples always fits after the shift.
  function automatic logic [SAMPLE_BITS-1:0] avg_trunc(input logic [ACC_W-1:0] acc,
                                                       input logic [2:0]       sh);
    return SAMPLE_BITS'(acc >> sh);
  endfunction

  // Requested exponent limited to what the accumulator width can hold.
  function automatic logic [2:0] clamp_log2(input logic [2:0] k);
    return (k > MAX_N) ? MAX_N : k;
  endfunction

  state_t state, state_nxt;

  logic busy_nxt, done_nxt, error_nxt, en_nxt, arst_nxt;
  logic latch, acc_add, avg_ld, ival_load, go_err;

  logic [2:0]       n_lat;
  logic [15:0]      ival_lat;
  logic [ACC_W-1:0] acc_a, acc_b;
  logic [ACC_W-1:0] sum_a, sum_b;
  logic [CNT_W-1:0] count, count_inc;
  logic [15:0]      ival_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [RC_W-1:0]  rst_cnt;

  logic last_sample, gap_done, tmo_hit, rst_done;

  assign sum_a       = acc_a + ACC_W'(adc_out_a);
  assign sum_b       = acc_b + ACC_W'(adc_out_b);
  assign count_inc   = count + CNT_W'(1);
  assign last_sample = (count_inc == (CNT_W'(1) << n_lat));
  // ival_cnt counts cycles since TRIG entry as seen in the current cycle, so
  // the next TRIG entry lands one cycle later: compare against cnt+1.
  assign gap_done    = (({1'b0, ival_cnt} + 17'd1) >= {1'b0, ival_lat});
  assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign rst_done    = (rst_cnt == RC_W'(RESET_CYCLES));

  // State register and registered handshake/status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_RST_ADC;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      adc_enable <= 1'b0;
      adc_reset  <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      adc_enable <= en_nxt;
      adc_reset  <= arst_nxt;
    end
  end

  // Next-state and output decode for the acquisition sequence.
  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    error_nxt = error;
    en_nxt    = adc_enable;
    arst_nxt  = 1'b0;
    latch     = 1'b0;
    acc_add   = 1'b0;
    avg_ld    = 1'b0;
    ival_load = 1'b0;
    go_err    = 1'b0;
    case (state)
      S_RST_ADC: begin
        if (rst_done) state_nxt = S_INIT_WAIT;
        else          arst_nxt  = 1'b1;
      end
      S_INIT_WAIT: begin
        if (adc_ready)    state_nxt = S_IDLE;
        else if (tmo_hit) go_err    = 1'b1;
      end
      S_IDLE: begin
        if (start) begin
          latch     = 1'b1;
          busy_nxt  = 1'b1;
          error_nxt = 1'b0;
          state_nxt = S_TRIG;
        end
      end
      S_TRIG: begin
        en_nxt    = 1'b1;
        ival_load = 1'b1;
        state_nxt = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!adc_ready) begin
          en_nxt    = 1'b0;
          state_nxt = S_WAIT_HIGH;
        end else if (tmo_hit) begin
          go_err = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (adc_ready) begin
          acc_add = 1'b1;
          if (last_sample) begin
            avg_ld    = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = S_FINISH;
          end else begin
            state_nxt = S_GAP;
          end
        end else if (tmo_hit) begin
          go_err = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_done) state_nxt = S_TRIG;
      end
      S_FINISH: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (start) begin
          error_nxt = 1'b0;
          state_nxt = S_RST_ADC;
        end
      end
      default: state_nxt = S_RST_ADC;
    endcase
    if (go_err) begin
      state_nxt = S_ERR;
      error_nxt = 1'b1;
      busy_nxt  = 1'b0;
      en_nxt    = 1'b0;
    end
  end

  // Measurement setup latch, accumulators, sample count and averaged outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      n_lat    <= '0;
      ival_lat <= '0;
      acc_a    <= '0;
      acc_b    <= '0;
      count    <= '0;
      avg_a    <= '0;
      avg_b    <= '0;
    end else begin
      if (latch) begin
        n_lat    <= clamp_log2(log2_avg);
        ival_lat <= interval;
        acc_a    <= '0;
        acc_b    <= '0;
        count    <= '0;
      end else if (acc_add) begin
        acc_a <= sum_a;
        acc_b <= sum_b;
        count <= count_inc;
      end
      if (avg_ld) begin
        avg_a <= avg_trunc(sum_a, n_lat);
        avg_b <= avg_trunc(sum_b, n_lat);
      end
    end
  end

  // Interval, wait-timeout and reset-pulse counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ival_cnt <= '0;
      tmo_cnt  <= '0;
      rst_cnt  <= '0;
    end else begin
      if (ival_load)                ival_cnt <= 16'd1;
      else if (ival_cnt != 16'hFFFF) ival_cnt <= ival_cnt + 16'd1;

      if (state_nxt != state) tmo_cnt <= '0;
      else if (!tmo_hit)      tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (state != S_RST_ADC) rst_cnt <= '0;
      else if (!rst_done)     rst_cnt <= rst_cnt + RC_W'(1);
    end
  end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// tb_adc_acq_sequencer
// Behavioural ADC controller model plus an averaging reference computed from
// the sample lists handed to the model.
`timescale 1ns/1ps
module tb_adc_acq_sequencer;

  localparam int SB   = 14;
  localparam int MAXL = 4;
  localparam int TMO  = 1023;
  localparam int RSTC = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    log2_avg = '0;
  logic [15:0]   interval = '0;
  logic          busy, done, error;
  logic [SB-1:0] avg_a, avg_b;
  logic          adc_enable, adc_reset;
  logic          adc_ready = 1'b0;
  logic [SB-1:0] adc_out_a = '0;
  logic [SB-1:0] adc_out_b = '0;

  int n_assert = 0;
  int n_fail   = 0;

  int stim_a[16];
  int stim_b[16];

  // ADC model and event recorders
  int   cyc = 0;
  int   conv_len = 10;
  bit   stuck = 1'b0;
  int   rtimer = 0;
  int   ctimer = 0;
  logic en_q = 1'b0;
  logic rs_q = 1'b0;
  logic er_q = 1'b0;
  int   rs_run = 0;
  int   last_rs_len = 0;
  int   rs_pulses = 0;
  int   en_rises = 0;
  int   last_en = 0;
  int   done_cnt = 0;
  int   err_time = 0;
  int   en_times[$];
  int   qa[$];
  int   qb[$];

  adc_acq_sequencer #(
    .SAMPLE_BITS (SB),
    .MAX_LOG2_AVG(MAXL),
    .TIMEOUT     (TMO),
    .RESET_CYCLES(RSTC)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .log2_avg  (log2_avg),
    .interval  (interval),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .avg_a     (avg_a),
    .avg_b     (avg_b),
    .adc_enable(adc_enable),
    .adc_reset (adc_reset),
    .adc_ready (adc_ready),
    .adc_out_a (adc_out_a),
    .adc_out_b (adc_out_b)
  );

  always #5 CLK = ~CLK;

  // ADC controller: acts on rising edges of adc_reset / adc_enable.
  always @(posedge CLK) begin
    bit en_rise;
    bit rs_rise;
    int ta;
    int tb;
    en_rise = adc_enable && !en_q;
    rs_rise = adc_reset && !rs_q;
    if (adc_reset) rs_run++;
    else if (rs_q) begin
      last_rs_len = rs_run;
      rs_pulses++;
      rs_run = 0;
    end
    if (en_rise) begin
      en_rises++;
      last_en = cyc;
      en_times.push_back(cyc);
    end
    if (error && !er_q) err_time = cyc;
    if (done) done_cnt++;
    if (rs_rise) begin
      adc_ready <= 1'b0;
      rtimer = 10;
      ctimer = 0;
    end else if (rtimer != 0) begin
      rtimer--;
      if (rtimer == 0) adc_ready <= 1'b1;
    end else if (en_rise && !stuck) begin
      adc_ready <= 1'b0;
      ctimer = conv_len;
    end else if (ctimer != 0) begin
      ctimer--;
      if (ctimer == 0) begin
        if (qa.size() != 0) ta = qa.pop_front(); else ta = 0;
        if (qb.size() != 0) tb = qb.pop_front(); else tb = 0;
        adc_out_a <= ta[SB-1:0];
        adc_out_b <= tb[SB-1:0];
        adc_ready <= 1'b1;
      end
    end
    en_q = adc_enable;
    rs_q = adc_reset;
    er_q = error;
    cyc++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int lo);
    for (int i = 0; i < 16; i++) begin
      stim_a[i] = int'($urandom_range(16383, lo));
      stim_b[i] = int'($urandom_range(16383, lo));
    end
  endtask

  // One measurement; expected averages, conversion count and spacing come
  // from the sample list and the pacing rule.
  task automatic measure(input int k, input int ivl, input int conv, input int poke);
    int n, ns, sa, sb, r0, d0, budget, spc;
    bit got;
    n  = (k > MAXL) ? MAXL : k;
    ns = 1 << n;
    qa.delete();
    qb.delete();
    en_times.delete();
    sa = 0;
    sb = 0;
    for (int i = 0; i < ns; i++) begin
      qa.push_back(stim_a[i]);
      qb.push_back(stim_b[i]);
      sa += stim_a[i];
      sb += stim_b[i];
    end
    spc    = (ivl > conv + 4) ? ivl : conv + 4;
    budget = ns * (spc + 4) + 50;
    conv_len = conv;
    r0 = en_rises;
    d0 = done_cnt;
    @(negedge CLK);
    log2_avg = 3'(k);
    interval = 16'(ivl);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("enable_latency_1", int'(adc_enable), 0);
    @(negedge CLK);
    check("enable_latency_2", int'(adc_enable), 1);
    got = 1'b0;
    for (int i = 1; i <= budget && !got; i++) begin
      @(negedge CLK);
      start = (poke != 0 && i == poke);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", int'(got), 1);
    check("busy_in_finish", int'(busy), 1);
    check("avg_a", int'(avg_a), sa >> n);
    check("avg_b", int'(avg_b), sb >> n);
    @(negedge CLK);
    check("done_one_cycle", int'(done), 0);
    check("busy_cleared", int'(busy), 0);
    check("conversions", en_rises - r0, ns);
    for (int i = 1; i < en_times.size(); i++)
      check("spacing", en_times[i] - en_times[i-1], spc);
    repeat ((poke != 0) ? 30 : 2) @(negedge CLK);
    check("no_extra_conv", en_rises - r0, ns);
    check("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int  p0, r0, d0, pa, pb;
    bit  got;

    // Power-up reset
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_avg_a", int'(avg_a), 0);
    check("rst_avg_b", int'(avg_b), 0);
    check("rst_adc_enable", int'(adc_enable), 0);
    check("rst_adc_reset", int'(adc_reset), 0);
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    check("pwrup_reset_pulses", rs_pulses, 1);
    check("pwrup_reset_len", last_rs_len, RSTC);
    check("pwrup_busy", int'(busy), 0);
    check("pwrup_error", int'(error), 0);
    check("pwrup_no_conv", en_rises, 0);

    // Single sample
    stim_a[0] = 'h1234;
    stim_b[0] = 'h0ABC;
    measure(0, 0, 20, 0);

    // Four-sample average, B at full scale
    stim_a[0] = 100; stim_a[1] = 101; stim_a[2] = 102; stim_a[3] = 104;
    for (int i = 0; i < 16; i++) stim_b[i] = 'h3FFF;
    measure(2, 0, 12, 0);

    // Exponent 7 clamps to 16 conversions; B stays at full scale
    fill_random(0);
    for (int i = 0; i < 16; i++) stim_b[i] = 'h3FFF;
    measure(7, 0, 5, 0);

    // Pacing: interval dominates, then back-to-back
    fill_random(1);
    measure(1, 200, 70, 0);
    fill_random(1);
    measure(1, 0, 70, 0);

    // Start pulsed mid-measurement is ignored
    fill_random(1);
    measure(1, 0, 30, 20);

    // Timeout in WAIT_LOW: ADC never drops ready
    stuck = 1'b1;
    pa = int'(avg_a);
    pb = int'(avg_b);
    d0 = done_cnt;
    @(negedge CLK);
    log2_avg = 3'd0;
    interval = 16'd0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < TMO + 50 && !got; i++) begin
      @(negedge CLK);
      if (error) got = 1'b1;
    end
    @(negedge CLK);
    check("tmo_error_seen", int'(got), 1);
    check("tmo_length", err_time - last_en, TMO);
    check("tmo_busy", int'(busy), 0);
    check("tmo_enable", int'(adc_enable), 0);
    check("tmo_no_done", done_cnt - d0, 0);
    check("tmo_avg_a_held", int'(avg_a), pa);
    check("tmo_avg_b_held", int'(avg_b), pb);

    // Start from ERR: re-initialise ADC only
    stuck = 1'b0;
    p0 = rs_pulses;
    r0 = en_rises;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("err_start_clears_error", int'(error), 0);
    check("err_start_busy", int'(busy), 0);
    repeat (30) @(negedge CLK);
    check("err_reset_pulses", rs_pulses - p0, 1);
    check("err_reset_len", last_rs_len, RSTC);
    check("err_no_conv", en_rises - r0, 0);
    check("err_idle_busy", int'(busy), 0);
    check("err_no_done", done_cnt - d0, 0);
    fill_random(1);
    measure(3, 10, 8, 0);

    // RST asserted while waiting for a conversion
    qa.delete();
    qb.delete();
    qa.push_back(1);
    qb.push_back(2);
    conv_len = 70;
    p0 = rs_pulses;
    d0 = done_cnt;
    @(negedge CLK);
    log2_avg = 3'd0;
    interval = 16'd0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (20) @(negedge CLK);
    check("mid_busy", int'(busy), 1);
    check("mid_enable_low", int'(adc_enable), 0);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_error", int'(error), 0);
    check("mid_rst_avg_a", int'(avg_a), 0);
    check("mid_rst_avg_b", int'(avg_b), 0);
    check("mid_rst_enable", int'(adc_enable), 0);
    check("mid_rst_adc_reset", int'(adc_reset), 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    check("mid_reset_pulses", rs_pulses - p0, 1);
    check("mid_reset_len", last_rs_len, RSTC);
    check("mid_idle_busy", int'(busy), 0);
    check("mid_no_done", done_cnt - d0, 0);

    // Randomised measurements
    for (int it = 0; it < 6; it++) begin
      fill_random(0);
      measure(int'($urandom_range(7, 0)), int'($urandom_range(40, 0)),
              int'($urandom_range(25, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
